mem_responder: RTL



---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Byte-serial data-memory responder: serves RV32I loads/stores one byte per cycle
// over a req/busy handshake. Optional macro MEM_RESP_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module mem_responder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    we_reg;
  logic [2:0]              f3_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             wdata_reg;
  logic [1:0]              last_reg;
  logic [1:0]              k_reg;
  logic                    rej_reg;
  logic [31:0]             rdata_reg;
  logic                    err_reg;

  logic                    legal;
  logic [1:0]              last_dec;
  logic [ADDR_WIDTH-1:0]   byte_addr;
  logic [7:0]              rd_byte;
  logic [7:0]              wr_byte;
  logic                    wr_en;
  logic [31:0]             asm_word;
  logic [31:0]             ext_word;
  logic                    unused_addr;

  logic [7:0] mem [DEPTH];

  assign unused_addr = &{1'b0, addr[31:ADDR_WIDTH]};

  // Width decode: last_dec is N-1, the final byte index of the access.
  always_comb begin
    legal    = 1'b0;
    last_dec = 2'd0;
    case (funct3)
      3'b000: begin legal = 1'b1; last_dec = 2'd0; end
      3'b001: begin legal = 1'b1; last_dec = 2'd1; end
      3'b010: begin legal = 1'b1; last_dec = 2'd3; end
      3'b100: begin legal = !we;  last_dec = 2'd0; end
      3'b101: begin legal = !we;  last_dec = 2'd1; end
      default: begin legal = 1'b0; last_dec = 2'd0; end
    endcase
`ifdef MEM_RESP_MISALIGN_TRAP_EN
    if ((funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00))
      legal = 1'b0;
`endif
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = req;
        if (req) state_next = legal ? ACTIVE : DONE;
      end
      ACTIVE: begin
        busy = 1'b1;
        if (k_reg == last_reg) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address wraps silently inside the RAM.
  assign byte_addr = addr_reg + ADDR_WIDTH'(k_reg);
  assign rd_byte   = mem[byte_addr];
  assign wr_byte   = wdata_reg[{k_reg, 3'b000} +: 8];
  assign wr_en     = (state_reg == ACTIVE) && we_reg && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) mem[byte_addr] <= wr_byte;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        lane <= 8'h00;
      else if (state_reg == IDLE && req)
        lane <= 8'h00;
      else if (state_reg == ACTIVE && !we_reg && k_reg == 2'(gi))
        lane <= rd_byte;
    end
    assign asm_word[gi*8 +: 8] = lane;
  end

  always_comb begin
    ext_word = asm_word;
    case (f3_reg)
      3'b000:  ext_word = {{24{asm_word[7]}}, asm_word[7:0]};
      3'b001:  ext_word = {{16{asm_word[15]}}, asm_word[15:0]};
      3'b100:  ext_word = {24'h0, asm_word[7:0]};
      3'b101:  ext_word = {16'h0, asm_word[15:0]};
      default: ext_word = asm_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      f3_reg    <= 3'b000;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      last_reg  <= 2'd0;
      k_reg     <= 2'd0;
      rej_reg   <= 1'b0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req) begin
            we_reg    <= we;
            f3_reg    <= funct3;
            addr_reg  <= addr[ADDR_WIDTH-1:0];
            wdata_reg <= wdata;
            last_reg  <= last_dec;
            k_reg     <= 2'd0;
            rej_reg   <= !legal;
          end
        end
        ACTIVE: k_reg <= k_reg + 2'd1;
        DONE: begin
          if (rej_reg) begin
            rdata_reg <= 32'h0;
            err_reg   <= 1'b1;
          end else begin
            if (!we_reg) rdata_reg <= ext_word;
            err_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = rdata_reg;
  assign err   = err_reg;

endmodule
